// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI test-pattern source: pattern mode codes,
// the colour-bar enable table and a constant-friendly clog2.
package hdmi_pkg;

   localparam logic [1:0] MODE_SOLID    = 2'd0;
   localparam logic [1:0] MODE_BARS     = 2'd1;
   localparam logic [1:0] MODE_CHECKER  = 2'd2;
   localparam logic [1:0] MODE_GRADIENT = 2'd3;

   // {R,G,B} full-scale enables; index 0 = white ... index 7 = black
   localparam logic [7:0][2:0] BAR_TABLE = {
      3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
   };

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters for the pattern source: h/v position, raw (unregistered)
// active-video and sync qualifiers, and line/frame end strobes.
module video_timing_gen
   import hdmi_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int CW_H    = clog2(H_TOTAL),
   localparam int CW_V    = clog2(V_TOTAL)
) (
   input  logic            sys_clk_i,
   input  logic            reset_n_i,
   output logic [CW_H-1:0] h_o,
   output logic [CW_V-1:0] v_o,
   output logic            de_o,
   output logic            hsyncAct_o,
   output logic            vsyncAct_o,
   output logic            lineEnd_o,
   output logic            frameEnd_o
);

   localparam logic [CW_H-1:0] H_LAST     = CW_H'(H_TOTAL - 1);
   localparam logic [CW_V-1:0] V_LAST     = CW_V'(V_TOTAL - 1);
   localparam logic [CW_H-1:0] H_ACT_END  = CW_H'(H_ACTIVE);
   localparam logic [CW_V-1:0] V_ACT_END  = CW_V'(V_ACTIVE);
   localparam logic [CW_H-1:0] HS_START   = CW_H'(H_ACTIVE + H_FP);
   localparam logic [CW_H-1:0] HS_END     = CW_H'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW_V-1:0] VS_START   = CW_V'(V_ACTIVE + V_FP);
   localparam logic [CW_V-1:0] VS_END     = CW_V'(V_ACTIVE + V_FP + V_SYNC);

   logic [CW_H-1:0] hCnt_q, hCnt_d;
   logic [CW_V-1:0] vCnt_q, vCnt_d;

   always_comb begin
      hCnt_d = hCnt_q + 1'b1;
      vCnt_d = vCnt_q;
      if (hCnt_q == H_LAST) begin
         hCnt_d = '0;
         vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + 1'b1;
      end
   end

   always_ff @(posedge sys_clk_i) begin
      if (!reset_n_i) begin
         hCnt_q <= '0;
         vCnt_q <= '0;
      end else begin
         hCnt_q <= hCnt_d;
         vCnt_q <= vCnt_d;
      end
   end

   assign h_o        = hCnt_q;
   assign v_o        = vCnt_q;
   assign de_o       = (hCnt_q < H_ACT_END) && (vCnt_q < V_ACT_END);
   assign hsyncAct_o = (hCnt_q >= HS_START) && (hCnt_q < HS_END);
   // vsync depends on the line only, so it spans whole lines
   assign vsyncAct_o = (vCnt_q >= VS_START) && (vCnt_q < VS_END);
   assign lineEnd_o  = (hCnt_q == H_LAST);
   assign frameEnd_o = (hCnt_q == H_LAST) && (vCnt_q == V_LAST);

endmodule

// File: rtl/hdmi_pattern_gen.sv
// Video timing plus test-pattern source for the HDMI transceiver; mode changes
// land on frame boundaries. Define HDMI_PATTERN_MOTION_EN to scroll patterns.
module hdmi_pattern_gen
   import hdmi_pkg::*;
#(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit HSYNC_POL  = 1'b0,
   parameter bit VSYNC_POL  = 1'b0,
   parameter int COLOR_W    = 8,
   parameter int CHECK_LOG2 = 5,
   localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int CW_H      = clog2(H_TOTAL),
   localparam int CW_V      = clog2(V_TOTAL)
) (
   input  logic                 sys_clk,
   input  logic                 reset_n,
   input  logic [1:0]           mode,
   input  logic [3*COLOR_W-1:0] solid_rgb,
   output logic [COLOR_W-1:0]   red,
   output logic [COLOR_W-1:0]   green,
   output logic [COLOR_W-1:0]   blue,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 de,
   output logic                 frame_start,
   output logic [CW_H-1:0]      hcount,
   output logic [CW_V-1:0]      vcount
);

   localparam int BAR_W = H_ACTIVE / 8;
   localparam int PW    = clog2(BAR_W) + 1;
   localparam logic [PW-1:0]   BAR_PIX_LAST = PW'(BAR_W - 1);
   localparam logic [CW_H-1:0] X_LAST       = CW_H'(H_ACTIVE - 1);

   logic [CW_H-1:0] h;
   logic [CW_V-1:0] v;
   logic            deNow, hsAct, vsAct, lineEnd, frameEnd;

   video_timing_gen #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
   ) uTiming (
      .sys_clk_i  (sys_clk),
      .reset_n_i  (reset_n),
      .h_o        (h),
      .v_o        (v),
      .de_o       (deNow),
      .hsyncAct_o (hsAct),
      .vsyncAct_o (vsAct),
      .lineEnd_o  (lineEnd),
      .frameEnd_o (frameEnd)
   );

   logic [1:0]         mode_q;
   logic [CW_H-1:0]    x;
   logic [2:0]         barIdx_q, barIdx_d, barLoadIdx, barEn;
   logic [PW-1:0]      barPix_q, barPix_d, barLoadPix;
   logic [COLOR_W-1:0] red_d, green_d, blue_d;
   logic [COLOR_W-1:0] red_q, green_q, blue_q;
   logic               hsync_q, vsync_q, de_q, fs_q;
   logic [CW_H-1:0]    hcount_q;
   logic [CW_V-1:0]    vcount_q;

   // One column step of a bar position; the last bar absorbs the remainder
   function automatic logic [PW+2:0] barStep(input logic [2:0] idx, input logic [PW-1:0] pix);
      if (idx == 3'd7) return {idx, pix};
      if (pix == BAR_PIX_LAST) return {idx + 3'd1, {PW{1'b0}}};
      return {idx, pix + 1'b1};
   endfunction

`ifdef HDMI_PATTERN_MOTION_EN
   localparam logic [CW_H:0] X_WRAP = (CW_H+1)'(H_ACTIVE);

   logic [CW_H-1:0] off_q, off_d;
   logic [2:0]      offIdx_q, offIdx_d;
   logic [PW-1:0]   offPix_q, offPix_d;
   logic [CW_H:0]   xSum;

   // The offset carries its own bar position so each line can preload it
   always_comb begin
      off_d    = off_q;
      offIdx_d = offIdx_q;
      offPix_d = offPix_q;
      if (frameEnd) begin
         if (off_q == X_LAST) begin
            off_d    = '0;
            offIdx_d = '0;
            offPix_d = '0;
         end else begin
            off_d                = off_q + 1'b1;
            {offIdx_d, offPix_d} = barStep(offIdx_q, offPix_q);
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         off_q    <= '0;
         offIdx_q <= '0;
         offPix_q <= '0;
      end else begin
         off_q    <= off_d;
         offIdx_q <= offIdx_d;
         offPix_q <= offPix_d;
      end
   end

   assign xSum       = {1'b0, h} + {1'b0, off_q};
   assign x          = (xSum >= X_WRAP) ? CW_H'(xSum - X_WRAP) : CW_H'(xSum);
   assign barLoadIdx = offIdx_d;
   assign barLoadPix = offPix_d;
`else
   assign x          = h;
   assign barLoadIdx = '0;
   assign barLoadPix = '0;
`endif

   always_comb begin
      {barIdx_d, barPix_d} = barStep(barIdx_q, barPix_q);
      if (x == X_LAST) begin
         barIdx_d = '0;
         barPix_d = '0;
      end
      if (lineEnd) begin
         barIdx_d = barLoadIdx;
         barPix_d = barLoadPix;
      end
   end

   always_comb begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
      barEn   = BAR_TABLE[barIdx_q];
      if (deNow) begin
         case (mode_q)
            MODE_SOLID:   {red_d, green_d, blue_d} = solid_rgb;
            MODE_BARS: begin
               red_d   = {COLOR_W{barEn[2]}};
               green_d = {COLOR_W{barEn[1]}};
               blue_d  = {COLOR_W{barEn[0]}};
            end
            MODE_CHECKER: begin
               if (x[CHECK_LOG2] ^ v[CHECK_LOG2]) begin
                  red_d   = '1;
                  green_d = '1;
                  blue_d  = '1;
               end
            end
            MODE_GRADIENT: begin
               red_d   = COLOR_W'(x);
               green_d = COLOR_W'(v);
               blue_d  = COLOR_W'(x) + COLOR_W'(v);
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         mode_q   <= MODE_SOLID;
         barIdx_q <= '0;
         barPix_q <= '0;
         red_q    <= '0;
         green_q  <= '0;
         blue_q   <= '0;
         hsync_q  <= ~HSYNC_POL;
         vsync_q  <= ~VSYNC_POL;
         de_q     <= 1'b0;
         fs_q     <= 1'b0;
         hcount_q <= '0;
         vcount_q <= '0;
      end else begin
         if (frameEnd) mode_q <= mode;
         barIdx_q <= barIdx_d;
         barPix_q <= barPix_d;
         red_q    <= red_d;
         green_q  <= green_d;
         blue_q   <= blue_d;
         hsync_q  <= hsAct ? HSYNC_POL : ~HSYNC_POL;
         vsync_q  <= vsAct ? VSYNC_POL : ~VSYNC_POL;
         de_q     <= deNow;
         fs_q     <= (h == '0) && (v == '0);
         hcount_q <= h;
         vcount_q <= v;
      end
   end

   assign red         = red_q;
   assign green       = green_q;
   assign blue        = blue_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign frame_start = fs_q;
   assign hcount      = hcount_q;
   assign vcount      = vcount_q;

endmodule
